// File: rtl/kyber_pkg.sv
// Shared Kyber constants and sampler FSM state type.
// Used by rej_sampler and its bench.
package kyber_pkg;

  localparam int KYBER_Q       = 3329;
  localparam int KYBER_N       = 256;
  localparam int SHAKE128_RATE = 1344;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLK,
    PARSE,
    DONE
  } rs_state_e;

endpackage

// File: rtl/rej_sampler.sv
// Kyber uniform rejection sampler: parses 12-bit
// candidates from SHAKE128 blocks, keeps those < Q.
module rej_sampler
  import kyber_pkg::*;
#(
  parameter int R       = SHAKE128_RATE,
  parameter int Q       = KYBER_Q,
  parameter int N       = KYBER_N,
  parameter int MAX_BLK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [R-1:0] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [11:0]  coeff_out,
  output logic         coeff_valid,
  output logic [7:0]   coeff_idx,
  output logic         done,
  output logic         err
);

  localparam int NCAND = R / 12;
  localparam int JW    = (NCAND > 1) ? $clog2(NCAND) : 1;
  localparam int CW    = $clog2(N + 1);
  localparam int BW    = $clog2(MAX_BLK + 1);
  localparam int AW    = JW + 4;

  localparam logic [JW-1:0] J_LAST = JW'(NCAND - 1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [BW-1:0] MB_C   = BW'(MAX_BLK);
  localparam logic [12:0]   Q_C    = 13'(Q);

  rs_state_e     state_q, state_d;
  logic [R-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [JW-1:0] j_q, j_d;
  logic [11:0]   cout_q, cout_d;
  logic          cval_q, cval_d;
  logic [7:0]    cidx_q, cidx_d;
  logic          err_q, err_d;

  logic [AW-1:0] base;
  logic [11:0]   cand;
  logic          accept;
  logic          last_c;
  logic          full;

  // Candidate j sits at bit 12*j = 8*j + 4*j.
  assign base   = ({4'b0, j_q} << 3) + ({4'b0, j_q} << 2);
  assign cand   = buf_q[base +: 12];
  assign accept = (state_q == PARSE) && ({1'b0, cand} < Q_C);
  assign last_c = (j_q == J_LAST);
  assign full   = accept && ((cnt_q + CW'(1)) == N_C);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: a full polynomial beats end-of-block.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (enable) state_d = WAIT_BLK;
      WAIT_BLK: if (block_valid) state_d = PARSE;
      PARSE: begin
        if (full)
          state_d = DONE;
        else if (last_c)
          state_d = (blk_q < MB_C) ? WAIT_BLK : DONE;
      end
      DONE:     if (!enable) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and registered datapath.
  always_comb begin
    block_ready = (state_q == WAIT_BLK);
    done        = (state_q == DONE);
    coeff_out   = cout_q;
    coeff_valid = cval_q;
    coeff_idx   = cidx_q;
    err         = err_q;
  end

  // Datapath next values: buffer, counters, coefficient strobe.
  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    blk_d  = blk_q;
    j_d    = j_q;
    cout_d = cout_q;
    cval_d = 1'b0;
    cidx_d = cidx_q;
    err_d  = err_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          cnt_d = '0;
          blk_d = '0;
          j_d   = '0;
          err_d = 1'b0;
        end
      end
      WAIT_BLK: begin
        if (block_valid) begin
          buf_d = block_in;
          blk_d = blk_q + BW'(1);
          j_d   = '0;
        end
      end
      PARSE: begin
        if (accept) begin
          cval_d = 1'b1;
          cout_d = cand;
          cidx_d = 8'(cnt_q);
          cnt_d  = cnt_q + CW'(1);
        end
        if (!last_c)
          j_d = j_q + JW'(1);
        else if (!full && (blk_q >= MB_C))
          err_d = 1'b1;
      end
      DONE: begin
        if (!enable) err_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      blk_q  <= '0;
      j_q    <= '0;
      cout_q <= '0;
      cval_q <= 1'b0;
      cidx_q <= '0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      j_q    <= j_d;
      cout_q <= cout_d;
      cval_q <= cval_d;
      cidx_q <= cidx_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_rej_sampler.sv
// Directed bench for rej_sampler.
// Scenario tasks run in sequence from one initial block.
module tb_rej_sampler;
  import kyber_pkg::*;

  localparam int R  = SHAKE128_RATE;
  localparam int NC = R / 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [R-1:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic [11:0]  coeff_out;
  logic         coeff_valid;
  logic [7:0]   coeff_idx;
  logic         done;
  logic         err;

  int total = 0;
  int bad   = 0;
  int cv_q[$];
  int ci_q[$];
  int hs_cnt = 0;
  logic prev_rdy = 1'b0;

  rej_sampler dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .coeff_out   (coeff_out),
    .coeff_valid (coeff_valid),
    .coeff_idx   (coeff_idx),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Collect strobes; count handshakes of the previous rising edge.
  always @(negedge clk) begin
    if (coeff_valid) begin
      cv_q.push_back(int'(coeff_out));
      ci_q.push_back(int'(coeff_idx));
    end
    if (prev_rdy && block_valid && rst) hs_cnt++;
    prev_rdy = block_ready;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    cv_q.delete();
    ci_q.delete();
    hs_cnt = 0;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    enable      = 1'b0;
    block_valid = 1'b0;
    block_in    = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    clear_log();
  endtask

  task automatic send_block(input logic [R-1:0] b, input bit keep);
    int n = 0;
    block_in    = b;
    block_valid = 1'b1;
    while (!block_ready && n < 500) begin
      tick();
      n++;
    end
    total++;
    if (!block_ready) begin
      bad++;
      $display("FAIL send_ready: got 0 want 1 within 500 cycles");
    end
    tick();
    if (!keep) block_valid = 1'b0;
  endtask

  task automatic wait_ready_or_done(input int budget);
    int n = 0;
    while (!block_ready && !done && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL wait_done: got 0 want 1 within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    enable      = 1'b1;
    block_valid = 1'b1;
    block_in    = '1;
    tick();
    tick();
    total++;
    if ({block_ready, coeff_valid, done, err} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {block_ready, coeff_valid, done, err});
    end
    total++;
    if ({coeff_out, coeff_idx} !== 20'd0) begin
      bad++;
      $display("FAIL reset_data: got out=%0d idx=%0d want 0 0",
               coeff_out, coeff_idx);
    end
    do_reset();
  endtask

  task automatic test_zeros();
    int nbad = 0;
    do_reset();
    enable = 1'b1;
    send_block('0, 1'b0);
    wait_ready_or_done(300);
    total++;
    if (cv_q.size() != 112) begin
      bad++;
      $display("FAIL zero_blk1_cnt: got %0d want 112", cv_q.size());
    end
    for (int i = 0; i < cv_q.size() && i < 112; i++) begin
      total++;
      if (cv_q[i] !== 0 || ci_q[i] !== i) begin
        bad++;
        nbad++;
        if (nbad < 5)
          $display("FAIL zero_blk1_coef: got val=%0d idx=%0d want 0 %0d",
                   cv_q[i], ci_q[i], i);
      end
    end
    total++;
    if (block_ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL zero_reready: got rdy=%b done=%b want 1 0",
               block_ready, done);
    end
    send_block('0, 1'b0);
    wait_ready_or_done(300);
    total++;
    if (cv_q.size() != 224) begin
      bad++;
      $display("FAIL zero_blk2_cnt: got %0d want 224", cv_q.size());
    end
    send_block('0, 1'b0);
    wait_ready_or_done(300);
    total++;
    if (done !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: got done=%b err=%b want 1 0", done, err);
    end
    total++;
    if (cv_q.size() != 256) begin
      bad++;
      $display("FAIL zero_total: got %0d want 256", cv_q.size());
    end
    for (int i = 224; i < cv_q.size() && i < 256; i++) begin
      total++;
      if (cv_q[i] !== 0 || ci_q[i] !== i) begin
        bad++;
        $display("FAIL zero_blk3_coef: got val=%0d idx=%0d want 0 %0d",
                 cv_q[i], ci_q[i], i);
      end
    end
    repeat (5) tick();
    total++;
    if (cv_q.size() != 256 || done !== 1'b1 || block_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_hold: got n=%0d done=%b rdy=%b want 256 1 0",
               cv_q.size(), done, block_ready);
    end
    enable = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL zero_release: got done=%b err=%b want 0 0", done, err);
    end
  endtask

  task automatic test_ones();
    do_reset();
    enable = 1'b1;
    for (int b = 0; b < 4; b++) begin
      send_block('1, 1'b0);
      wait_ready_or_done(300);
    end
    total++;
    if (done !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL ones_err: got done=%b err=%b want 1 1", done, err);
    end
    total++;
    if (cv_q.size() != 0 || block_ready !== 1'b0) begin
      bad++;
      $display("FAIL ones_nocoef: got n=%0d rdy=%b want 0 0",
               cv_q.size(), block_ready);
    end
    enable = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL ones_release: got done=%b err=%b want 0 0", done, err);
    end
  endtask

  task automatic test_boundary();
    logic [R-1:0] b;
    b         = '1;
    b[11:0]   = 12'd3328;
    b[23:12]  = 12'd3329;
    b[35:24]  = 12'd0;
    do_reset();
    enable = 1'b1;
    send_block(b, 1'b0);
    tick();
    total++;
    if (coeff_valid !== 1'b1 || coeff_out !== 12'd3328 || coeff_idx !== 8'd0) begin
      bad++;
      $display("FAIL bnd_3328: got v=%b out=%0d idx=%0d want 1 3328 0",
               coeff_valid, coeff_out, coeff_idx);
    end
    tick();
    total++;
    if (coeff_valid !== 1'b0) begin
      bad++;
      $display("FAIL bnd_3329: got v=%b want 0", coeff_valid);
    end
    tick();
    total++;
    if (coeff_valid !== 1'b1 || coeff_out !== 12'd0 || coeff_idx !== 8'd1) begin
      bad++;
      $display("FAIL bnd_zero: got v=%b out=%0d idx=%0d want 1 0 1",
               coeff_valid, coeff_out, coeff_idx);
    end
    tick();
    total++;
    if (coeff_valid !== 1'b0) begin
      bad++;
      $display("FAIL bnd_4095: got v=%b want 0", coeff_valid);
    end
    do_reset();
  endtask

  task automatic test_hold_valid();
    do_reset();
    enable = 1'b1;
    send_block('0, 1'b1);
    block_in = '1;
    wait_done(2000);
    total++;
    if (hs_cnt != 4) begin
      bad++;
      $display("FAIL hold_handshakes: got %0d want 4", hs_cnt);
    end
    total++;
    if (cv_q.size() != 112 || err !== 1'b1) begin
      bad++;
      $display("FAIL hold_result: got n=%0d err=%b want 112 1",
               cv_q.size(), err);
    end
    block_valid = 1'b0;
    enable      = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    int n = 0;
    do_reset();
    enable = 1'b1;
    send_block('0, 1'b0);
    while (cv_q.size() < 50 && n < 200) begin
      tick();
      n++;
    end
    rst = 1'b0;
    tick();
    total++;
    if ({block_ready, coeff_valid, done, err} !== 4'b0 ||
        {coeff_out, coeff_idx} !== 20'd0) begin
      bad++;
      $display("FAIL midrst_out: got rdy=%b v=%b d=%b e=%b out=%0d idx=%0d want all 0",
               block_ready, coeff_valid, done, err, coeff_out, coeff_idx);
    end
    tick();
    total++;
    if (cv_q.size() != 50) begin
      bad++;
      $display("FAIL midrst_count: got %0d want 50", cv_q.size());
    end
    rst = 1'b1;
    clear_log();
    send_block('0, 1'b0);
    tick();
    tick();
    total++;
    if (cv_q.size() < 1) begin
      bad++;
      $display("FAIL midrst_restart: got 0 coefficients want >=1");
    end else if (ci_q[0] !== 0) begin
      bad++;
      $display("FAIL midrst_restart: got idx=%0d want 0", ci_q[0]);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [R-1:0] blks[4];
    int exp_q[$];
    int c;
    int nbad = 0;
    bit exp_err;
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < R / 32; w++)
        blks[b][32*w +: 32] = $urandom;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < NC; j++) begin
        c = int'(blks[b][12*j +: 12]);
        if (exp_q.size() < KYBER_N && c < KYBER_Q) exp_q.push_back(c);
      end
    exp_err = (exp_q.size() < KYBER_N);
    do_reset();
    enable = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wait_ready_or_done(300);
      if (done) break;
      send_block(blks[b], 1'b0);
    end
    wait_done(300);
    total++;
    if (cv_q.size() != exp_q.size() || err !== exp_err) begin
      bad++;
      $display("FAIL rand_count: got n=%0d err=%b want %0d %b",
               cv_q.size(), err, exp_q.size(), exp_err);
    end
    for (int i = 0; i < exp_q.size() && i < cv_q.size(); i++) begin
      total++;
      if (cv_q[i] !== exp_q[i] || ci_q[i] !== i) begin
        bad++;
        nbad++;
        if (nbad < 5)
          $display("FAIL rand_coef: got val=%0d idx=%0d want %0d %0d",
                   cv_q[i], ci_q[i], exp_q[i], i);
      end
    end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_boundary();
    test_hold_valid();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
